uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage.
- Consumes the board-level, already two-flop-synchronized RX line and delivers bytes to the mother_board core over a valid/ready handshake.
- Frame format is 8N1: 1 start bit, 8 data bits LSB first, no parity, 1 stop bit.
- Bit timing is set by a clocks-per-bit parameter, WAIT = CLOCK_HZ / UART_BAUD_RATE.

Parameters:
- WAIT, 868, clock cycles per bit; legal range 4 or more (868 = 100 MHz / 115200).
- DATA_BITS, 8, data bits per frame; fixed at 8 and taken from the package.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- uart_rx  input  1  synchronized serial input; idle level is 1
- rx_data  output  8  received byte; stable while rx_valid is high
- rx_valid  output  1  rx_data holds an unconsumed byte
- rx_ready  input  1  consumer accepts the byte in any cycle where rx_valid && rx_ready
- rx_frame_err  output  1  one-cycle pulse: stop bit sampled as 0
- rx_overrun  output  1  one-cycle pulse: a frame completed while the holding register was full; the new byte is dropped

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, bit counter=0, baud counter=0, shift register=0.
  - rx_data=0x00, rx_valid=0, rx_frame_err=0, rx_overrun=0.
  - Reset asserted mid-frame aborts the frame immediately; the partial byte is discarded.
- States: IDLE, START, DATA, STOP, RECOVER.
- IDLE:
  - Baud counter held at 0.
  - The first cycle with uart_rx==0 is cycle T0; go to START and load the baud counter.
- START:
  - At T0 + WAIT/2 (integer division), sample uart_rx.
  - Sample 0: go to DATA and reload the counter for a full bit.
  - Sample 1: the low was a glitch; return to IDLE with no output and no error.
- DATA:
  - Data bit i (i = 0..7) is sampled at T0 + WAIT/2 + (i+1)*WAIT.
  - Each sample shifts in MSB-side so bit 0 ends at rx_data[0].
  - After bit 7, go to STOP.
- STOP: sample at T0 + WAIT/2 + 9*WAIT.
  - Sample 1, holding register empty (or emptied this same cycle by a handshake): load rx_data and set rx_valid in the following cycle; go to IDLE.
  - Sample 1, holding register full with no handshake this cycle: pulse rx_overrun for one cycle; rx_data and rx_valid are unchanged; go to IDLE.
  - Sample 0: pulse rx_frame_err for one cycle and discard the byte; go to RECOVER.
- RECOVER: wait for uart_rx==1 (break or line low), then go to IDLE. This prevents a held-low line from being taken as a new start bit.
- Handshake:
  - rx_valid clears in the cycle after rx_valid && rx_ready.
  - If a pop and a new load occur in the same cycle, the new byte wins: rx_valid stays 1 and rx_data updates, with no overrun.
  - rx_ready is ignored while rx_valid==0.
- Frame-to-frame: IDLE is re-entered at the stop-bit mid-sample, so a back-to-back start bit half a bit later is caught without loss.
- Counters:
  - Baud counter width is $clog2(WAIT) and it counts down to 0.
  - Bit counter is 3 bits and has no wrap beyond 7.
- Latency: rx_valid rises at T0 + WAIT/2 + 9*WAIT + 1.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [2:0] rx_state_t {IDLE, START, DATA, STOP, RECOVER}
  - localparam DATA_BITS = 8
  - These are shared with the future transmitter.
- Sub-module uart_baud_timer: a loadable down-counter with load value (WAIT or WAIT/2) and a one-cycle tick output at 0. The transmitter will reuse it.
- The holding register and handshake stay inline.

Test Plan (WAIT=8 for simulation speed):
- Send byte 0x55 with rx_ready held 1 → rx_valid pulses 1 cycle at T0+77 with rx_data=0x55; no error pulses.
- Send 0xA3 then 0x0F back-to-back with rx_ready=0 → 0xA3 is held; the second frame gives one rx_overrun pulse; rx_data stays 0xA3. Then raise rx_ready → rx_valid drops the next cycle.
- Send 0x3C with the stop bit forced to 0 and the line held low 20 cycles → one rx_frame_err pulse; rx_valid stays 0; no new frame starts until the line returns high. A following 0x81 is received correctly.
- Drive a 2-cycle low glitch on an idle line → no rx_valid, no error; the FSM is back in IDLE by T0+5.
- Assert reset during data bit 4 of 0xFF → all outputs are 0 immediately. Release, then send 0x12 → rx_data=0x12 with rx_valid=1.
- Hold rx_valid with a byte and pulse rx_ready in exactly the stop-sample cycle of the next frame 0x99 → no overrun; rx_data=0x99 and rx_valid stays 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// Used by the receiver now and the transmitter later.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    RECOVER
  } rx_state_t;

endpackage

// File: rtl/uart_baud_timer.sv
// Loadable down-counter for bit timing.
// Ticks while at zero; reload with a full or half bit period.
module uart_baud_timer #(
  parameter int WAIT = 868
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load_full,
  input  logic i_load_half,
  output logic o_tick
);

  localparam int CW = $clog2(WAIT);
  localparam logic [CW-1:0] FULL = CW'(WAIT - 1);
  localparam logic [CW-1:0] HALF = CW'(WAIT / 2 - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load_full) begin
      r_cnt <= FULL;
    end else if (i_load_half) begin
      r_cnt <= HALF;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receive stage with a one-byte holding register
// and valid/ready handoff to the core.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int WAIT = 868
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  rx_state_t            r_state;
  rx_state_t            w_next;
  logic [2:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

  logic w_tick;
  logic w_load_full;
  logic w_load_half;
  logic w_shift;
  logic w_stop;
  logic w_accept;

  uart_baud_timer #(
    .WAIT(WAIT)
  ) u_timer (
    .i_clk      (clk),
    .i_rst      (reset),
    .i_load_full(w_load_full),
    .i_load_half(w_load_half),
    .o_tick     (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_load_full = 1'b0;
    w_load_half = 1'b0;
    w_shift     = 1'b0;
    w_stop      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!uart_rx) begin
          w_next      = START;
          w_load_half = 1'b1;
        end
      end
      START: begin
        if (w_tick) begin
          if (!uart_rx) begin
            w_next      = DATA;
            w_load_full = 1'b1;
          end else begin
            w_next = IDLE;
          end
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shift     = 1'b1;
          w_load_full = 1'b1;
          if (r_bit == 3'(DATA_BITS - 1)) w_next = STOP;
        end
      end
      STOP: begin
        if (w_tick) begin
          w_stop = 1'b1;
          w_next = uart_rx ? IDLE : RECOVER;
        end
      end
      RECOVER: begin
        if (uart_rx) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // A pop in the stop-sample cycle frees the slot for the new byte.
  assign w_accept = w_stop && uart_rx && (!r_valid || rx_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit       <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_load_half) r_bit <= '0;
      else if (w_shift) r_bit <= r_bit + 3'd1;
      if (w_shift) r_shift <= {uart_rx, r_shift[DATA_BITS-1:1]};
      r_frame_err <= w_stop && !uart_rx;
      r_overrun   <= w_stop && uart_rx && r_valid && !rx_ready;
      if (w_accept) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data      = r_data;
  assign rx_valid     = r_valid;
  assign rx_frame_err = r_frame_err;
  assign rx_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at WAIT=8.
// Frame table plus hand-written overrun/error/glitch/reset sequences.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int W   = 8;
  localparam int LAT = W / 2 + 9 * W + 1;

  logic       clk;
  logic       reset;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_frame_err;
  logic       rx_overrun;

  uart_receiver #(
    .WAIT(W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .uart_rx     (uart_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_frame_err(rx_frame_err),
    .rx_overrun  (rx_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_rise = 0;
  int         n_fall = 0;
  int         n_err  = 0;
  int         n_ovr  = 0;
  int         n_vhi  = 0;
  int         rise_cyc = 0;
  logic [7:0] cap = '0;
  logic       prev_v = 1'b0;

  always @(negedge clk) begin
    if (rx_valid && !prev_v) begin
      n_rise   = n_rise + 1;
      rise_cyc = cyc;
      cap      = rx_data;
    end
    if (!rx_valid && prev_v) n_fall = n_fall + 1;
    if (rx_valid) n_vhi = n_vhi + 1;
    if (rx_frame_err) n_err = n_err + 1;
    if (rx_overrun) n_ovr = n_ovr + 1;
    prev_v = rx_valid;
  end

  int total = 0;
  int pass  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Call at a negedge; returns at the negedge ending the stop bit.
  task automatic send(input logic [7:0] d, input logic stopb,
                      output int t0);
    uart_rx = 1'b0;
    t0 = cyc;
    repeat (W) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (W) @(negedge clk);
    end
    uart_rx = stopb;
    repeat (W) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stopb;
    int         exp_rise;
    logic [7:0] exp_data;
    int         exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, t1, r0, f0, e0, o0, h0;
    vecs[0] = '{8'h55, 1'b1, 1, 8'h55, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 8'h00, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
    vecs[3] = '{8'h80, 1'b1, 1, 8'h80, 0};
    vecs[4] = '{8'h01, 1'b1, 1, 8'h01, 0};
    vecs[5] = '{8'hC3, 1'b0, 0, 8'h00, 1};

    uart_rx  = 1'b1;
    rx_ready = 1'b1;
    reset    = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data", rx_data, 0);
    check("reset_valid", rx_valid, 0);
    check("reset_err", rx_frame_err, 0);
    check("reset_ovr", rx_overrun, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    foreach (vecs[k]) begin
      r0 = n_rise; e0 = n_err; o0 = n_ovr; h0 = n_vhi;
      send(vecs[k].data, vecs[k].stopb, t0);
      uart_rx = 1'b1;
      repeat (12) @(negedge clk);
      check($sformatf("v%0d_rise", k), n_rise - r0, vecs[k].exp_rise);
      check($sformatf("v%0d_err", k), n_err - e0, vecs[k].exp_err);
      check($sformatf("v%0d_ovr", k), n_ovr - o0, 0);
      check($sformatf("v%0d_vwidth", k), n_vhi - h0, vecs[k].exp_rise);
      if (n_rise > r0) begin
        check($sformatf("v%0d_data", k), cap, vecs[k].exp_data);
        check($sformatf("v%0d_lat", k), rise_cyc - t0, LAT);
      end
    end

    // Back-to-back frames into a full holding register.
    rx_ready = 1'b0;
    r0 = n_rise; o0 = n_ovr; e0 = n_err;
    send(8'hA3, 1'b1, t0);
    send(8'h0F, 1'b1, t1);
    repeat (3) @(negedge clk);
    check("ovr_count", n_ovr - o0, 1);
    check("ovr_rise", n_rise - r0, 1);
    check("ovr_data", rx_data, 8'hA3);
    check("ovr_valid", rx_valid, 1);
    check("ovr_err", n_err - e0, 0);
    rx_ready = 1'b1;
    check("pop_before", rx_valid, 1);
    @(negedge clk);
    check("pop_after", rx_valid, 0);

    // Stop bit low, line then held low.
    r0 = n_rise; e0 = n_err;
    send(8'h3C, 1'b0, t0);
    repeat (20) @(negedge clk);
    check("ferr_count", n_err - e0, 1);
    check("ferr_valid", rx_valid, 0);
    check("ferr_recover", int'(dut.r_state), int'(RECOVER));
    uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    send(8'h81, 1'b1, t0);
    repeat (4) @(negedge clk);
    check("after_ferr_rise", n_rise - r0, 1);
    check("after_ferr_data", cap, 8'h81);
    check("after_ferr_lat", rise_cyc - t0, LAT);
    check("after_ferr_err", n_err - e0, 1);

    // Two-cycle glitch on an idle line.
    r0 = n_rise; e0 = n_err;
    uart_rx = 1'b0;
    t0 = cyc;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("glitch_cyc", cyc - t0, 5);
    check("glitch_idle", int'(dut.r_state), int'(IDLE));
    repeat (90) @(negedge clk);
    check("glitch_rise", n_rise - r0, 0);
    check("glitch_err", n_err - e0, 0);

    // Reset during data bit 4 of 0xFF.
    uart_rx = 1'b0;
    repeat (W) @(negedge clk);
    uart_rx = 1'b1;
    repeat (4 * W + 3) @(negedge clk);
    check("pre_rst_data", rx_data, 8'h81);
    reset = 1'b1;
    #1;
    check("rst_data", rx_data, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_err", rx_frame_err, 0);
    check("rst_ovr", rx_overrun, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    r0 = n_rise;
    rx_ready = 1'b0;
    send(8'h12, 1'b1, t0);
    repeat (2) @(negedge clk);
    check("post_rst_rise", n_rise - r0, 1);
    check("post_rst_data", rx_data, 8'h12);
    check("post_rst_valid", rx_valid, 1);
    check("post_rst_lat", rise_cyc - t0, LAT);

    // Pop exactly in the stop-sample cycle of the next frame.
    f0 = n_fall; o0 = n_ovr;
    fork
      send(8'h99, 1'b1, t1);
      begin
        repeat (LAT - 1) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    check("same_cyc_ovr", n_ovr - o0, 0);
    check("same_cyc_data", rx_data, 8'h99);
    check("same_cyc_valid", rx_valid, 1);
    check("same_cyc_nofall", n_fall - f0, 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
